// File: rtl/vc_pop_arbiter_pkg.sv
// Shared definitions for the VC pop arbiter.
//   - state_t: FSM state encodings (RESET=0, INIT=1, IDLE=2, ACTIVE=3)
//   - DATA_SIZE_DEF / CNT_SIZE_DEF: default widths for head words and pop counters
//   - dest_almost_full(): selects the almost-full flag of the destination FIFO
package vc_pop_arbiter_pkg;

  localparam int DATA_SIZE_DEF = 4;
  localparam int CNT_SIZE_DEF  = 8;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_INIT   = 2'd1,
    ST_IDLE   = 2'd2,
    ST_ACTIVE = 2'd3
  } state_t;

  // Destination bit 0 routes to D0, 1 routes to D1.
  function automatic logic dest_almost_full(input logic dest_bit,
                                            input logic d0_af,
                                            input logic d1_af);
    return dest_bit ? d1_af : d0_af;
  endfunction

endpackage

// File: rtl/vc_pop_arbiter_pop_counter.sv
// Wrapping pop counter used once per virtual channel.
// Ports:
//   clk, reset : clock and asynchronous active-high reset
//   clr        : synchronous clear (wins over en)
//   en         : increment by one this cycle
//   cnt        : current count, wraps from all-ones to zero
module pop_counter #(
  parameter int CNT_SIZE = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr,
  input  logic                en,
  output logic [CNT_SIZE-1:0] cnt
);

  logic [CNT_SIZE-1:0] cnt_d;
  logic [CNT_SIZE-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_SIZE'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/vc_pop_arbiter.sv
// Pops words from two virtual-channel FIFOs towards two destination FIFOs
// (D0/D1), with strict VC0 priority and no bypass: a blocked VC0 head also
// stalls VC1, preserving ordering across channels.
// Ports:
//   clk, reset                 : clock, asynchronous active-high reset
//   init                       : forces INIT state while high
//   vc0_empty, vc1_empty       : VC FIFO empty flags
//   vc0_head, vc1_head         : FWFT head words, MSB selects destination
//   d0_almost_full, d1_almost_full : destination back-pressure
//   pop_vc0, pop_vc1           : combinational read strobes
//   pop_delay_vc0/vc1          : read strobes delayed one cycle
//   state                      : current FSM state
//   pop_cnt_vc0/vc1            : per-VC pop counts
module vc_pop_arbiter
  import vc_pop_arbiter_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int CNT_SIZE  = CNT_SIZE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 vc0_empty,
  input  logic                 vc1_empty,
  input  logic [DATA_SIZE-1:0] vc0_head,
  input  logic [DATA_SIZE-1:0] vc1_head,
  input  logic                 d0_almost_full,
  input  logic                 d1_almost_full,
  output logic                 pop_vc0,
  output logic                 pop_vc1,
  output logic                 pop_delay_vc0,
  output logic                 pop_delay_vc1,
  output logic [1:0]           state,
  output logic [CNT_SIZE-1:0]  pop_cnt_vc0,
  output logic [CNT_SIZE-1:0]  pop_cnt_vc1
);

  state_t state_d, state_q;
  logic   pop_delay_vc0_d, pop_delay_vc0_q;
  logic   pop_delay_vc1_d, pop_delay_vc1_q;
  logic   vc0_blocked, vc1_blocked;
  logic   active;
  logic   cnt_clr;

  // Only the destination bit of each head word matters here.
  logic   unused_head_bits;
  assign unused_head_bits = ^{vc0_head[DATA_SIZE-2:0], vc1_head[DATA_SIZE-2:0]};

  // Next-state logic; init overrides every other transition.
  always_comb begin
    state_d = state_q;
    if (init) begin
      state_d = ST_INIT;
    end else begin
      case (state_q)
        ST_RESET:  state_d = ST_INIT;
        ST_INIT:   state_d = ST_IDLE;
        ST_IDLE:   if (!vc0_empty || !vc1_empty) state_d = ST_ACTIVE;
        ST_ACTIVE: if (vc0_empty && vc1_empty)   state_d = ST_IDLE;
        default:   state_d = ST_RESET;
      endcase
    end
  end

  // Pop strobes are combinational so a pop and its almost-full suppression
  // resolve in the same cycle.
  always_comb begin
    active      = (state_q == ST_ACTIVE);
    vc0_blocked = dest_almost_full(vc0_head[DATA_SIZE-1], d0_almost_full, d1_almost_full);
    vc1_blocked = dest_almost_full(vc1_head[DATA_SIZE-1], d0_almost_full, d1_almost_full);
    pop_vc0     = active && !vc0_empty && !vc0_blocked;
    // vc0_empty gate gives strict priority and prevents VC1 bypassing a stalled VC0.
    pop_vc1     = active && vc0_empty && !vc1_empty && !vc1_blocked;
  end

  // A pop issued in the cycle that init arrives is not forwarded into INIT.
  always_comb begin
    pop_delay_vc0_d = (state_d == ST_INIT) ? 1'b0 : pop_vc0;
    pop_delay_vc1_d = (state_d == ST_INIT) ? 1'b0 : pop_vc1;
    cnt_clr         = (state_d == ST_INIT);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_RESET;
      pop_delay_vc0_q <= 1'b0;
      pop_delay_vc1_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      pop_delay_vc0_q <= pop_delay_vc0_d;
      pop_delay_vc1_q <= pop_delay_vc1_d;
    end
  end

  assign state         = state_q;
  assign pop_delay_vc0 = pop_delay_vc0_q;
  assign pop_delay_vc1 = pop_delay_vc1_q;

  pop_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt_vc0 (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (pop_vc0),
    .cnt   (pop_cnt_vc0)
  );

  pop_counter #(.CNT_SIZE(CNT_SIZE)) u_cnt_vc1 (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (pop_vc1),
    .cnt   (pop_cnt_vc1)
  );

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// Self-checking bench for vc_pop_arbiter: table-driven cycle vectors with a
// queue of expected delayed pops, then hand-written counter-wrap and
// asynchronous-reset sequences.
module tb_vc_pop_arbiter;

  logic       clk;
  logic       reset;
  logic       init;
  logic       vc0_empty, vc1_empty;
  logic [3:0] vc0_head, vc1_head;
  logic       d0_almost_full, d1_almost_full;
  logic       pop_vc0, pop_vc1;
  logic       pop_delay_vc0, pop_delay_vc1;
  logic [1:0] state;
  logic [7:0] pop_cnt_vc0, pop_cnt_vc1;

  int checks = 0;
  int errors = 0;

  vc_pop_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .init           (init),
    .vc0_empty      (vc0_empty),
    .vc1_empty      (vc1_empty),
    .vc0_head       (vc0_head),
    .vc1_head       (vc1_head),
    .d0_almost_full (d0_almost_full),
    .d1_almost_full (d1_almost_full),
    .pop_vc0        (pop_vc0),
    .pop_vc1        (pop_vc1),
    .pop_delay_vc0  (pop_delay_vc0),
    .pop_delay_vc1  (pop_delay_vc1),
    .state          (state),
    .pop_cnt_vc0    (pop_cnt_vc0),
    .pop_cnt_vc1    (pop_cnt_vc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       init;
    logic       e0;
    logic       e1;
    logic [3:0] h0;
    logic [3:0] h1;
    logic       af0;
    logic       af1;
    logic [1:0] st;
    logic       p0;
    logic       p1;
    logic [7:0] c0;
    logic [7:0] c1;
  } vec_t;

  typedef struct {
    logic p0;
    logic p1;
  } pop_t;

  localparam logic [1:0] S_RESET  = 2'd0;
  localparam logic [1:0] S_INIT   = 2'd1;
  localparam logic [1:0] S_IDLE   = 2'd2;
  localparam logic [1:0] S_ACTIVE = 2'd3;

  localparam int NVEC = 20;
  vec_t vecs[NVEC];
  pop_t sb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Compare delayed pops against the oldest queued expectation.
  task automatic chk_delay(input string nm, input logic in_init);
    pop_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty actual=%0b%0b required=entry", nm,
               pop_delay_vc0, pop_delay_vc1);
    end else begin
      e = sb_q.pop_front();
      chk({nm, "_dly0"}, {31'd0, pop_delay_vc0}, {31'd0, e.p0 & ~in_init});
      chk({nm, "_dly1"}, {31'd0, pop_delay_vc1}, {31'd0, e.p1 & ~in_init});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //            init e0  e1  h0     h1     af0 af1 state     p0 p1 c0 c1
    vecs[0]  = '{1'b1,1'b1,1'b1,4'h0,4'h0,1'b0,1'b0,S_RESET, 1'b0,1'b0,8'd0,8'd0};
    vecs[1]  = '{1'b1,1'b1,1'b1,4'h0,4'h0,1'b0,1'b0,S_INIT,  1'b0,1'b0,8'd0,8'd0};
    vecs[2]  = '{1'b0,1'b1,1'b1,4'h0,4'h0,1'b0,1'b0,S_INIT,  1'b0,1'b0,8'd0,8'd0};
    vecs[3]  = '{1'b0,1'b1,1'b1,4'h0,4'h0,1'b0,1'b0,S_IDLE,  1'b0,1'b0,8'd0,8'd0};
    vecs[4]  = '{1'b0,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_IDLE,  1'b0,1'b0,8'd0,8'd0};
    vecs[5]  = '{1'b0,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_ACTIVE,1'b1,1'b0,8'd0,8'd0};
    vecs[6]  = '{1'b0,1'b1,1'b1,4'h3,4'h0,1'b0,1'b0,S_ACTIVE,1'b0,1'b0,8'd1,8'd0};
    vecs[7]  = '{1'b0,1'b1,1'b1,4'h0,4'h0,1'b0,1'b0,S_IDLE,  1'b0,1'b0,8'd1,8'd0};
    vecs[8]  = '{1'b0,1'b0,1'b0,4'h8,4'h5,1'b0,1'b1,S_IDLE,  1'b0,1'b0,8'd1,8'd0};
    vecs[9]  = '{1'b0,1'b0,1'b0,4'h8,4'h5,1'b0,1'b1,S_ACTIVE,1'b0,1'b0,8'd1,8'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,4'h8,4'h5,1'b0,1'b0,S_ACTIVE,1'b1,1'b0,8'd1,8'd0};
    vecs[11] = '{1'b0,1'b1,1'b0,4'h8,4'h5,1'b0,1'b0,S_ACTIVE,1'b0,1'b1,8'd2,8'd0};
    vecs[12] = '{1'b0,1'b1,1'b0,4'h8,4'h5,1'b1,1'b0,S_ACTIVE,1'b0,1'b0,8'd2,8'd1};
    vecs[13] = '{1'b0,1'b0,1'b0,4'h3,4'h8,1'b1,1'b0,S_ACTIVE,1'b0,1'b0,8'd2,8'd1};
    vecs[14] = '{1'b0,1'b0,1'b0,4'h8,4'h8,1'b1,1'b0,S_ACTIVE,1'b1,1'b0,8'd2,8'd1};
    vecs[15] = '{1'b1,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_ACTIVE,1'b1,1'b0,8'd3,8'd1};
    vecs[16] = '{1'b1,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_INIT,  1'b0,1'b0,8'd0,8'd0};
    vecs[17] = '{1'b0,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_INIT,  1'b0,1'b0,8'd0,8'd0};
    vecs[18] = '{1'b0,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_IDLE,  1'b0,1'b0,8'd0,8'd0};
    vecs[19] = '{1'b0,1'b0,1'b1,4'h3,4'h0,1'b0,1'b0,S_ACTIVE,1'b1,1'b0,8'd0,8'd0};

    reset = 1'b1; init = 1'b1; vc0_empty = 1'b1; vc1_empty = 1'b1;
    vc0_head = 4'h0; vc1_head = 4'h0; d0_almost_full = 1'b0; d1_almost_full = 1'b0;

    // Reset state while reset is held
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", {30'd0, state}, {30'd0, S_RESET});
    chk("rst_pops",  {30'd0, pop_vc0, pop_vc1}, 32'd0);
    chk("rst_dly",   {30'd0, pop_delay_vc0, pop_delay_vc1}, 32'd0);
    chk("rst_cnt",   {16'd0, pop_cnt_vc0, pop_cnt_vc1}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Table-driven cycles
    for (int i = 0; i < NVEC; i++) begin
      init           = vecs[i].init;
      vc0_empty      = vecs[i].e0;
      vc1_empty      = vecs[i].e1;
      vc0_head       = vecs[i].h0;
      vc1_head       = vecs[i].h1;
      d0_almost_full = vecs[i].af0;
      d1_almost_full = vecs[i].af1;
      @(negedge clk);
      chk($sformatf("v%0d_state", i), {30'd0, state}, {30'd0, vecs[i].st});
      chk($sformatf("v%0d_pop0", i), {31'd0, pop_vc0}, {31'd0, vecs[i].p0});
      chk($sformatf("v%0d_pop1", i), {31'd0, pop_vc1}, {31'd0, vecs[i].p1});
      chk($sformatf("v%0d_cnt0", i), {24'd0, pop_cnt_vc0}, {24'd0, vecs[i].c0});
      chk($sformatf("v%0d_cnt1", i), {24'd0, pop_cnt_vc1}, {24'd0, vecs[i].c1});
      if (i > 0) chk_delay($sformatf("v%0d", i), vecs[i].st == S_INIT);
      sb_q.push_back('{vecs[i].p0, vecs[i].p1});
      @(posedge clk); #1;
    end

    // VC1-only traffic for 257 cycles: counter runs up to 255 then wraps to 0
    begin
      logic [7:0] exp_c1;
      exp_c1 = 8'd0;
      init = 1'b0; vc0_empty = 1'b1; vc1_empty = 1'b0; vc1_head = 4'h5;
      d0_almost_full = 1'b0; d1_almost_full = 1'b0;
      for (int k = 0; k <= 256; k++) begin
        @(negedge clk);
        chk($sformatf("w%0d_pop1", k), {31'd0, pop_vc1}, 32'd1);
        chk($sformatf("w%0d_cnt1", k), {24'd0, pop_cnt_vc1}, {24'd0, exp_c1});
        chk_delay($sformatf("w%0d", k), 1'b0);
        if (k == 0) chk("w_cnt0_hold", {24'd0, pop_cnt_vc0}, 32'd1);
        sb_q.push_back('{1'b0, 1'b1});
        exp_c1 = exp_c1 + 8'd1;
        @(posedge clk); #1;
      end
      chk("wrap_cnt1_zero", {24'd0, pop_cnt_vc1}, 32'd1);
    end

    // Asynchronous reset in the middle of a cycle with a pop in flight
    chk("ar_pre_pop1", {31'd0, pop_vc1}, 32'd1);
    chk("ar_pre_dly1", {31'd0, pop_delay_vc1}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_dly1",  {31'd0, pop_delay_vc1}, 32'd0);
    chk("ar_pop1",  {31'd0, pop_vc1}, 32'd0);
    chk("ar_cnt",   {16'd0, pop_cnt_vc0, pop_cnt_vc1}, 32'd0);
    chk("ar_state", {30'd0, state}, {30'd0, S_RESET});
    @(posedge clk); #1;
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
